cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Arbitrates the common data bus (CDB) among NUM_REQ result producers (branch unit, ALU, LSU, ...).
//  Grants at most one requester per cycle, then drives a registered broadcast (cdb_index/cdb_result).
//  The PC, reservation stations and ROB consume this broadcast.
//  Idle cycles drive cdb_index = NO_LOCK, so lock comparators in consumers never match spuriously.
// PARAMETERS
//  NUM_REQ   4    number of requesters; index 0 is the branch unit
//  TAG_W     4    width of the lock/ROB tag, equal to `Reg_Lock_Width
//  DATA_W    32   result width, equal to `Inst_Addr_Width
//  NO_LOCK   0    tag value meaning "no lock"; driven on cdb_index when idle
// PORTS
//  clk         in   1               clock; all logic is on posedge
//  rst         in   1               synchronous, active-high reset
//  req         in   NUM_REQ         per-requester valid; held until granted
//  req_tag     in   NUM_REQ*TAG_W   packed tags; requester i occupies bits [i*TAG_W +: TAG_W]
//  req_data    in   NUM_REQ*DATA_W  packed results, same packing as req_tag
//  gnt         out  NUM_REQ         one-hot combinational grant
//  rob_modify  in   1               flush (mispredict); suppresses grant and broadcast
//  cdb_valid   out  1               registered; broadcast valid
//  cdb_index   out  TAG_W           registered tag; NO_LOCK when cdb_valid=0
//  cdb_result  out  DATA_W          registered result; 0 when cdb_valid=0
// BEHAVIOUR
//  - Reset (rst=1 at posedge), whether idle or mid-operation:
//    cdb_valid=0, cdb_index=NO_LOCK, cdb_result=0, rr_ptr=0.
//    gnt=0 combinationally while rst=1. Any pending req is not consumed.
//  - Handshake:
//    - Requester i asserts req[i] with stable req_tag/req_data.
//    - Transfer occurs in the cycle where gnt[i]=1 (combinational from req, rr_ptr, rob_modify, rst).
//    - The requester may drop req or present the next result in the following cycle.
//    - A requester must not deassert req without gnt; the bench asserts this.
//  - Grant rule (round-robin): search req starting at rr_ptr and ascending modulo NUM_REQ.
//    The first set bit wins. gnt is all-zero if req==0, rob_modify=1 or rst=1.
//  - rr_ptr update: when a grant to requester k fires, rr_ptr <= (k+1) mod NUM_REQ
//    (wrap-around at NUM_REQ-1 goes to 0). Unchanged otherwise.
//  - Latency: one cycle. A grant in cycle t gives cdb_valid=1, cdb_index=req_tag[k],
//    cdb_result=req_data[k] during cycle t+1, for exactly one cycle per grant.
//  - No grant in cycle t: cdb_valid=0, cdb_index=NO_LOCK, cdb_result=0 in cycle t+1.
//  - Back-to-back grants allowed every cycle; the bus has 100% throughput.
//  - rob_modify=1 in cycle t:
//    - no grant in cycle t, so requesters keep their req;
//    - the broadcast register is cleared for t+1;
//    - a broadcast already visible in cycle t is not retracted.
//  - The arbiter buffers nothing beyond the single output register, so fullness cannot occur.
//    Back-pressure is expressed only through gnt.
//  - A tag equal to NO_LOCK is forwarded unchanged (it is illegal at the source; the bench asserts on it).
// CONFIGURATION
//  CDB_FIXED_PRIO_EN defined:
//   - fixed priority: lowest index wins, so the branch unit (0) always beats the others;
//   - rr_ptr is removed (stays 0);
//   - gives minimum PC-unlock latency but allows starvation of high indices.
//  CDB_FIXED_PRIO_EN undefined (default): round-robin as above; starvation-free.
//   Any continuously requesting source is granted within NUM_REQ cycles.
// TESTING
//  1. Reset: hold rst=1 for 2 cycles with req=4'b1111
//     -> gnt=0; cdb_valid=0, cdb_index=0, cdb_result=0; first grant after rst drops goes to req 0.
//  2. Single request: req=4'b0100, tag 5, data 32'h0000_0010 at t
//     -> gnt=4'b0100 at t; cdb_valid=1, index 5, result 32'h10 at t+1; idle again at t+2.
//  3. Round-robin with req=4'b1111 held for 8 cycles
//     -> grant order 0,1,2,3,0,1,2,3; cdb_valid=1 every cycle.
//     Under CDB_FIXED_PRIO_EN: order 0,0,0,... and requesters 1-3 are never granted.
//  4. Wrap-around: rr_ptr=3 (previous grant to 2), req=4'b1001
//     -> grant 3, then grant 0, then rr_ptr=1.
//  5. Flush: req=4'b0010 and rob_modify=1 at t
//     -> gnt=0 at t; cdb_valid=0 at t+1; rob_modify=0 at t+1 -> gnt=4'b0010 at t+1, broadcast at t+2.
//  6. Reset mid-stream: rst=1 one cycle after a grant to requester 2
//     -> the broadcast from that grant still appears; the next cycle shows cdb_valid=0 and rr_ptr=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-hot combinational grant, registered one-cycle broadcast of the winner's tag/result.
// Round-robin by default; define CDB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module cdb_arbiter #(
  parameter int                NUM_REQ = 4,
  parameter int                TAG_W   = 4,
  parameter int                DATA_W  = 32,
  parameter logic [TAG_W-1:0]  NO_LOCK = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        rob_modify,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_index,
  output logic [DATA_W-1:0]           cdb_result
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic              win_any;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  int                idx;

  // Scan req starting at rr_ptr, wrapping modulo NUM_REQ; first set bit wins.
  always_comb begin
    gnt      = '0;
    win_any  = 1'b0;
    win_idx  = '0;
    win_tag  = NO_LOCK;
    win_data = '0;
    idx      = 0;
    if (!rst && !rob_modify) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(rr_ptr) + i) % NUM_REQ;
        if (!win_any && req[idx]) begin
          win_any      = 1'b1;
          win_idx      = PTR_W'(idx);
          gnt[idx]     = 1'b1;
          win_tag      = req_tag[idx*TAG_W +: TAG_W];
          win_data     = req_data[idx*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef CDB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (win_any) begin
      rr_ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  // Idle and flushed cycles drive NO_LOCK so consumer lock comparators never match.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid  <= 1'b0;
      cdb_index  <= NO_LOCK;
      cdb_result <= '0;
    end else begin
      cdb_valid  <= win_any;
      cdb_index  <= win_any ? win_tag : NO_LOCK;
      cdb_result <= win_any ? win_data : '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts, a monitor pops and compares.
module tb_cdb_arbiter;

  localparam int NR = 4;
  localparam int TW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*TW-1:0] req_tag;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   gnt;
  logic            rob_modify;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_index;
  logic [DW-1:0]   cdb_result;

  cdb_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .DATA_W(DW), .NO_LOCK(4'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_tag    (req_tag),
    .req_data   (req_data),
    .gnt        (gnt),
    .rob_modify (rob_modify),
    .cdb_valid  (cdb_valid),
    .cdb_index  (cdb_index),
    .cdb_result (cdb_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sbq[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            seq = 0;
  logic [TW-1:0] tag_v [NR];
  logic [DW-1:0] data_v[NR];
  logic [NR-1:0] pend = '0;
  logic [NR-1:0] prev_pend = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol checks on the stimulus side: held requests and legal tags.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        if (prev_pend[i] && !req[i]) $error("requester %0d dropped req without grant", i);
        if (req[i] && req_tag[i*TW +: TW] == 4'd0) $error("requester %0d presents NO_LOCK tag", i);
      end
    end
    prev_pend <= rst ? '0 : (req & ~gnt);
  end

  // Monitor: every cycle after the first reset edge, compare the broadcast register.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (cdb_valid) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL bcast_unexpected cyc %0d: got valid idx=%0d res=%h, want none", cyc, cdb_index, cdb_result);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (e.cyc != cyc || cdb_index !== e.tag || cdb_result !== e.data) begin
            n_err++;
            $display("FAIL bcast cyc %0d: got idx=%0d res=%h, want cyc %0d idx=%0d res=%h",
                     cyc, cdb_index, cdb_result, e.cyc, e.tag, e.data);
          end
        end
      end else begin
        n_cmp++;
        if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
          n_err++;
          $display("FAIL bcast_missing cyc %0d: got valid=0, want idx=%0d res=%h", cyc, sbq[0].tag, sbq[0].data);
          void'(sbq.pop_front());
        end else if (cdb_index !== 4'd0 || cdb_result !== 32'd0) begin
          n_err++;
          $display("FAIL idle_bus cyc %0d: got idx=%0d res=%h, want idx=0 res=0", cyc, cdb_index, cdb_result);
        end
      end
    end
  end

  // New payload only for requesters not still waiting on a grant.
  task automatic load_payload();
    seq++;
    for (int i = 0; i < NR; i++) begin
      if (!pend[i]) begin
        tag_v[i]  = TW'(((seq + i) % 15) + 1);
        data_v[i] = 32'hC0DE_0000 | (32'(seq) << 4) | 32'(i);
      end
    end
  endtask

  task automatic step(input logic [NR-1:0] r, input logic rb, input logic rs,
                      input logic [NR-1:0] eg, input string nm);
    req        = r;
    rob_modify = rb;
    rst        = rs;
    for (int i = 0; i < NR; i++) begin
      req_tag[i*TW +: TW]  = tag_v[i];
      req_data[i*DW +: DW] = data_v[i];
    end
    @(negedge clk);
    n_cmp++;
    if (gnt !== eg) begin
      n_err++;
      $display("FAIL gnt_%s cyc %0d: got %b want %b", nm, cyc, gnt, eg);
    end
    for (int k = 0; k < NR; k++) begin
      if (eg[k]) sbq.push_back('{cyc + 1, tag_v[k], data_v[k]});
    end
    pend = rs ? '0 : (r & ~eg);
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [NR-1:0] r, input logic rb, input logic rs,
                    input logic [NR-1:0] eg, input string nm);
    load_payload();
    step(r, rb, rs, eg, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; req_tag = '0; req_data = '0; rob_modify = 1'b0; rst = 1'b1;
    // Reset held with all requesting: no grant.
    go(4'b1111, 1'b0, 1'b1, 4'b0000, "reset0");
    go(4'b1111, 1'b0, 1'b1, 4'b0000, "reset1");
    // Round-robin over 8 cycles, then drain the leftovers.
    go(4'b1111, 1'b0, 1'b0, 4'b0001, "rr0");
    go(4'b1111, 1'b0, 1'b0, 4'b0010, "rr1");
    go(4'b1111, 1'b0, 1'b0, 4'b0100, "rr2");
    go(4'b1111, 1'b0, 1'b0, 4'b1000, "rr3");
    go(4'b1111, 1'b0, 1'b0, 4'b0001, "rr4");
    go(4'b1111, 1'b0, 1'b0, 4'b0010, "rr5");
    go(4'b1111, 1'b0, 1'b0, 4'b0100, "rr6");
    go(4'b1111, 1'b0, 1'b0, 4'b1000, "rr7");
    go(4'b0111, 1'b0, 1'b0, 4'b0001, "drain0");
    go(4'b0110, 1'b0, 1'b0, 4'b0010, "drain1");
    go(4'b0100, 1'b0, 1'b0, 4'b0100, "drain2");
    go(4'b0000, 1'b0, 1'b0, 4'b0000, "idle0");
    // Single request with a known payload; rr_ptr is 3 here.
    load_payload();
    tag_v[2]  = 4'd5;
    data_v[2] = 32'h0000_0010;
    step(4'b0100, 1'b0, 1'b0, 4'b0100, "single");
    go(4'b0000, 1'b0, 1'b0, 4'b0000, "idle1");
    // Wrap-around: rr_ptr=3 with req 1001 -> 3, then 0, then rr_ptr=1.
    go(4'b1001, 1'b0, 1'b0, 4'b1000, "wrap3");
    go(4'b0001, 1'b0, 1'b0, 4'b0001, "wrap0");
    go(4'b0011, 1'b0, 1'b0, 4'b0010, "ptr1");
    go(4'b0001, 1'b0, 1'b0, 4'b0001, "ptr1_rest");
    // Flush while the previous broadcast is on the bus.
    go(4'b0010, 1'b1, 1'b0, 4'b0000, "flush");
    go(4'b0010, 1'b0, 1'b0, 4'b0010, "post_flush");
    // Reset one cycle after a grant to requester 2.
    go(4'b0100, 1'b0, 1'b0, 4'b0100, "pre_rst");
    go(4'b1111, 1'b0, 1'b1, 4'b0000, "mid_rst");
    go(4'b1111, 1'b0, 1'b0, 4'b0001, "after_rst");
    go(4'b1110, 1'b0, 1'b0, 4'b0010, "tail1");
    go(4'b1100, 1'b0, 1'b0, 4'b0100, "tail2");
    go(4'b1000, 1'b0, 1'b0, 4'b1000, "tail3");
    go(4'b0000, 1'b0, 1'b0, 4'b0000, "idle2");
    go(4'b0000, 1'b0, 1'b0, 4'b0000, "idle3");
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending broadcasts, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
